// File: rtl/han_carlson_subtractor_pipe.sv
// 16-bit three-stage pipelined subtractor (a + ~b + 1) on a Han-Carlson prefix tree,
// with valid/ready flow control, per-stage bubble collapsing and a sideband tag.
module han_carlson_subtractor_pipe #(
    parameter int unsigned TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      a,
    input  logic [15:0]      b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      diff,
    output logic             borrow,
    output logic             ovf,
    output logic             zero,
    output logic [TAG_W-1:0] out_tag
);

    logic             v1_q, v2_q, v3_q;
    logic             free1, free2, free3;
    logic [15:0]      s1_p_q, s1_g_q, s1_pp_q;
    logic             s1_a15_q, s1_b15_q;
    logic [TAG_W-1:0] s1_tag_q;
    logic [15:0]      s2_p_q, s2_g_q, s2_pp_q;
    logic             s2_a15_q, s2_b15_q;
    logic [TAG_W-1:0] s2_tag_q;
    logic [15:0]      diff_q;
    logic             borrow_q, ovf_q, zero_q;
    logic [TAG_W-1:0] tag_q;

    logic [15:0] p_in, gg_in, s1_g_d, s1_pp_d;
    logic [15:0] lvl2_g, lvl2_pp, s2_g_d, s2_pp_d;
    logic [15:0] carry, diff_d;
    logic        borrow_d, ovf_d, zero_d;
    logic        unused_pp;

    // A stage is free when empty or when it hands its content downstream this cycle.
    assign free3    = !v3_q || out_ready;
    assign free2    = !v2_q || free3;
    assign free1    = !v1_q || free2;
    assign in_ready = free1;

    // Stage 1: bit propagate/generate with the carry-in folded into bit 0, then odd pairs.
    always_comb begin
        p_in     = a ^ ~b;
        gg_in    = a & ~b;
        gg_in[0] = gg_in[0] | p_in[0];
        s1_g_d   = gg_in;
        s1_pp_d  = p_in;
        for (int unsigned i = 1; i < 16; i += 2) begin
            s1_g_d[i]  = gg_in[i] | (p_in[i] & gg_in[i-1]);
            s1_pp_d[i] = p_in[i] & p_in[i-1];
        end
    end

    // Stage 2: odd-bit groups widen to 4 then 8 bits.
    always_comb begin
        lvl2_g  = s1_g_q;
        lvl2_pp = s1_pp_q;
        for (int unsigned i = 3; i < 16; i += 2) begin
            lvl2_g[i]  = s1_g_q[i] | (s1_pp_q[i] & s1_g_q[i-2]);
            lvl2_pp[i] = s1_pp_q[i] & s1_pp_q[i-2];
        end
        s2_g_d  = lvl2_g;
        s2_pp_d = lvl2_pp;
        for (int unsigned i = 5; i < 16; i += 2) begin
            s2_g_d[i]  = lvl2_g[i] | (lvl2_pp[i] & lvl2_g[i-4]);
            s2_pp_d[i] = lvl2_pp[i] & lvl2_pp[i-4];
        end
    end

    // Stage 3: finish odd carries at span 16, then fill even carries from their odd neighbour.
    always_comb begin
        carry = s2_g_q;
        for (int unsigned i = 9; i < 16; i += 2) begin
            carry[i] = s2_g_q[i] | (s2_pp_q[i] & s2_g_q[i-8]);
        end
        for (int unsigned i = 2; i < 16; i += 2) begin
            carry[i] = s2_g_q[i] | (s2_p_q[i] & carry[i-1]);
        end
        diff_d       = '0;
        diff_d[0]    = ~s2_p_q[0];
        diff_d[15:1] = s2_p_q[15:1] ^ carry[14:0];
        borrow_d     = ~carry[15];
        ovf_d        = (s2_a15_q != s2_b15_q) && (diff_d[15] != s2_a15_q);
        zero_d       = ~|diff_d;
    end

    // Group-propagate terms of bits that already reach bit 0 are not needed in stage 3.
    assign unused_pp = ^s2_pp_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_q     <= 1'b0;
            v2_q     <= 1'b0;
            v3_q     <= 1'b0;
            s1_p_q   <= '0;
            s1_g_q   <= '0;
            s1_pp_q  <= '0;
            s1_a15_q <= 1'b0;
            s1_b15_q <= 1'b0;
            s1_tag_q <= '0;
            s2_p_q   <= '0;
            s2_g_q   <= '0;
            s2_pp_q  <= '0;
            s2_a15_q <= 1'b0;
            s2_b15_q <= 1'b0;
            s2_tag_q <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
            tag_q    <= '0;
        end else begin
            if (free1) begin
                v1_q <= in_valid;
                if (in_valid) begin
                    s1_p_q   <= p_in;
                    s1_g_q   <= s1_g_d;
                    s1_pp_q  <= s1_pp_d;
                    s1_a15_q <= a[15];
                    s1_b15_q <= b[15];
                    s1_tag_q <= in_tag;
                end
            end
            if (free2) begin
                v2_q <= v1_q;
                if (v1_q) begin
                    s2_p_q   <= s1_p_q;
                    s2_g_q   <= s2_g_d;
                    s2_pp_q  <= s2_pp_d;
                    s2_a15_q <= s1_a15_q;
                    s2_b15_q <= s1_b15_q;
                    s2_tag_q <= s1_tag_q;
                end
            end
            if (free3) begin
                v3_q <= v2_q;
                if (v2_q) begin
                    diff_q   <= diff_d;
                    borrow_q <= borrow_d;
                    ovf_q    <= ovf_d;
                    zero_q   <= zero_d;
                    tag_q    <= s2_tag_q;
                end
            end
        end
    end

    assign out_valid = v3_q;
    assign diff      = diff_q;
    assign borrow    = borrow_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;
    assign out_tag   = tag_q;

endmodule

// File: doc/han_carlson_subtractor_pipe.md
Name: han_carlson_subtractor_pipe

Overview:
- 16-bit, 3-stage pipelined two's-complement subtractor: diff = a - b, computed as a + ~b + 1 on a Han-Carlson parallel-prefix carry tree.
- It is the subtract counterpart of the team's combinational 16-bit Han-Carlson adder, for datapaths that need registered timing and flow control.
- Uses valid/ready handshakes on input and output, with per-stage bubble collapsing; a user tag travels alongside each operand pair.

Parameters:
- TAG_W, 4, width of the sideband tag carried with each operation (1..8).

Ports:
- clk  input  1  clock, rising-edge.
- rst_n  input  1  reset, synchronous, active-low.
- in_valid  input  1  operand pair present.
- in_ready  output  1  block accepts operands this cycle.
- a  input  16  minuend.
- b  input  16  subtrahend.
- in_tag  input  TAG_W  sideband tag.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts result.
- diff  output  16  a - b, modulo 2^16.
- borrow  output  1  1 when unsigned a < unsigned b.
- ovf  output  1  signed overflow of a - b.
- zero  output  1  diff == 0.
- out_tag  output  TAG_W  tag of the result.

Behaviour:
- Reset: when rst_n=0 at a clk edge, all three stage-valid bits clear.
  - out_valid=0; diff, borrow, ovf, zero and out_tag are 0.
  - in_ready=1 from the first cycle after reset.
  - Reset mid-operation discards all in-flight results; none are emitted afterwards.
- Transfers: input transfer is in_valid && in_ready; output transfer is out_valid && out_ready.
- Stage 1 (registered at the accept edge): bit p/g from a and ~b, then Han-Carlson first level (odd-bit pairs).
  - Carry-in 1 is folded into bit 0: G0 = g0 | p0.
  - Per-bit p, the level-1 group terms, a[15], b[15] and the tag are registered.
- Stage 2: prefix levels 2 and 3 (span 4 and 8 on odd bits, plus the low-order group resolution), registered.
- Stage 3: level 4 completes the odd carries; level 5 fills the even carries.
  - diff[i] = p[i] ^ c[i-1]; diff[0] = ~p[0] (carry-in 1).
  - borrow = ~c[15].
  - ovf = (a15 != b15) && (diff15 != a15).
  - zero = ~|diff.
  - Results are registered as the outputs.
- Latency: exactly 3 cycles from input transfer to out_valid, with no stall. Throughput is 1 per cycle.
- Flow control: stage k is "free" if its valid bit is 0 or it advances this cycle.
  - Stage 3 advances when out_ready=1.
  - Stage k<3 advances into stage k+1 when stage k+1 is free.
  - in_ready = stage-1 free. It is combinational from out_ready through the chain; there is no registered skid.
- Bubble collapsing: an empty stage accepts from its upstream stage even while stage 3 is stalled. Three results can be held while out_ready=0, and in_ready drops only when all three stages are full.
- Stall stability: while out_valid=1 and out_ready=0, diff, borrow, ovf, zero and out_tag hold stable.
- Ordering: results emerge in acceptance order, with no loss or duplication.
- Simultaneous events: an input transfer and an output transfer in the same cycle with the pipe full is legal and keeps the pipe full.
- Ignored inputs: a, b and in_tag are ignored when in_valid=0 or in_ready=0.
- Arithmetic: all results are modulo 2^16.
  - a=b gives diff=0, zero=1, borrow=0.
  - b=0 gives borrow=0, ovf=0.

Test Plan:
- Reset then single op, out_ready=1: a=0x1234, b=0x0234, tag=5 -> out_valid 3 cycles later, diff=0x1000, borrow=0, ovf=0, zero=0, out_tag=5.
- Wrap/borrow: a=0x0000, b=0x0001 -> diff=0xFFFF, borrow=1, ovf=0. Then a=0x8000, b=0x0001 -> diff=0x7FFF, borrow=0, ovf=1. Then a=0x7FFF, b=0xFFFF -> diff=0x8000, borrow=1, ovf=1.
- Full carry chain: a=b=0xA5A5 -> diff=0, zero=1, borrow=0. Then a=0xFFFF, b=0x0000 -> diff=0xFFFF, borrow=0.
- Backpressure: stream 6 ops with out_ready=0 -> exactly 3 accepted, in_ready=0 afterwards, outputs stable. Raise out_ready -> all 6 delivered in order with correct tags.
- Bubbles and random traffic: random in_valid/out_ready over 10k random operands -> results match the a-b scoreboard, in order, with no drops.
- Reset mid-stream: assert rst_n=0 with 3 ops in flight -> out_valid=0 next cycle, in_ready=1; no stale result ever appears.
